// File: rtl/adsr_poly.sv
// adsr_poly: time-multiplexed multi-voice ADSR envelope generator.
//
// One shared update engine services NUM_VOICES voices round-robin, one voice
// per clk, starting on an accepted sample tick. Each voice keeps its own
// state, level and stored gate. The coefficients and sustain are latched at
// sweep start and shared by every voice in that sweep.
//
// Ports:
//   clk           clock
//   reset         asynchronous, active-high reset
//   tick          sample strobe, starts one sweep (ignored while busy/done)
//   gate          per-voice note gate
//   attack_coef   signed fixed-point attack coefficient, 0..one
//   decay_coef    signed fixed-point decay coefficient, 0..one
//   release_coef  signed fixed-point release coefficient, 0..one
//   sustain       sustain amplitude (AMPLITUDE_BITS wide)
//   out           per-voice amplitude, voice i at [i*AMPLITUDE_BITS +: AMPLITUDE_BITS]
//   active        per-voice state != IDLE
//   busy          sweep in progress
//   done          one-cycle pulse after the last voice of a sweep
//
// Optional build macro: ADSR_POLY_HARD_RETRIG_EN
//   defined   - a rising gate edge also forces the voice level to 0
//   undefined - soft retrigger, attack resumes from the current level

module adsr_poly #(
    parameter int  NUM_VOICES      = 8,
    parameter int  TOTAL_BITS      = 32,
    parameter int  FRACTIONAL_BITS = 16,
    parameter int  AMPLITUDE_BITS  = 8,
    parameter real ATTACK_RATIO    = 0.3,
    parameter real DECAY_RATIO     = 0.0001,
    parameter real RELEASE_RATIO   = 0.0001
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 tick,
    input  logic [NUM_VOICES-1:0]                gate,
    input  logic [TOTAL_BITS-1:0]                attack_coef,
    input  logic [TOTAL_BITS-1:0]                decay_coef,
    input  logic [TOTAL_BITS-1:0]                release_coef,
    input  logic [AMPLITUDE_BITS-1:0]            sustain,
    output logic [NUM_VOICES*AMPLITUDE_BITS-1:0] out,
    output logic [NUM_VOICES-1:0]                active,
    output logic                                 busy,
    output logic                                 done
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    localparam logic signed [TOTAL_BITS-1:0] ONE =
        TOTAL_BITS'((64'sd1 <<< FRACTIONAL_BITS) - 64'sd1);
    localparam logic signed [TOTAL_BITS-1:0] ATTACK_RATIO_F =
        TOTAL_BITS'($rtoi(ATTACK_RATIO * (2.0 ** FRACTIONAL_BITS)));
    localparam logic signed [TOTAL_BITS-1:0] DECAY_RATIO_F =
        TOTAL_BITS'($rtoi(DECAY_RATIO * (2.0 ** FRACTIONAL_BITS)));
    localparam logic signed [TOTAL_BITS-1:0] RELEASE_RATIO_F =
        TOTAL_BITS'($rtoi(RELEASE_RATIO * (2.0 ** FRACTIONAL_BITS)));

    typedef enum logic [4:0] {
        S_IDLE    = 5'b00001,
        S_ATTACK  = 5'b00010,
        S_DECAY   = 5'b00100,
        S_SUSTAIN = 5'b01000,
        S_RELEASE = 5'b10000
    } state_t;

    // Fixed-point multiply: full-width signed product, arithmetic shift, truncate.
    function automatic logic signed [TOTAL_BITS-1:0] fmul(
        input logic signed [TOTAL_BITS-1:0] a,
        input logic signed [TOTAL_BITS-1:0] b
    );
        logic signed [2*TOTAL_BITS-1:0] ax;
        logic signed [2*TOTAL_BITS-1:0] bx;
        logic signed [2*TOTAL_BITS-1:0] p;
        ax = a;
        bx = b;
        p  = (ax * bx) >>> FRACTIONAL_BITS;
        return p[TOTAL_BITS-1:0];
    endfunction

    state_t                         state_r [NUM_VOICES];
    logic signed [TOTAL_BITS-1:0]   level_r [NUM_VOICES];
    logic [NUM_VOICES-1:0]          gate_q;
    logic [IDX_W-1:0]               idx;

    logic signed [TOTAL_BITS-1:0]   attack_l, decay_l, release_l;
    logic [AMPLITUDE_BITS-1:0]      sustain_l;
    logic signed [TOTAL_BITS-1:0]   sustain_f;

    state_t                         cur_state, next_state;
    logic signed [TOTAL_BITS-1:0]   cur_level, next_level;
    logic signed [TOTAL_BITS-1:0]   base_a, base_d, base_r, n;
    logic                           cur_gate, old_gate;

    assign sustain_f = TOTAL_BITS'({sustain_l, {(FRACTIONAL_BITS-AMPLITUDE_BITS){1'b0}}});

    always_comb begin
        cur_state  = state_r[idx];
        cur_level  = level_r[idx];
        cur_gate   = gate[idx];
        old_gate   = gate_q[idx];
        next_state = cur_state;
        next_level = cur_level;
        base_a     = fmul(ONE + ATTACK_RATIO_F, ONE - attack_l);
        base_d     = fmul(sustain_f - DECAY_RATIO_F, ONE - decay_l);
        base_r     = fmul(-RELEASE_RATIO_F, ONE - release_l);
        n          = '0;

        if (cur_gate && !old_gate) begin
            next_state = S_ATTACK;
`ifdef ADSR_POLY_HARD_RETRIG_EN
            next_level = '0;
`endif
        end else if (!cur_gate && old_gate) begin
            if (cur_state != S_IDLE)
                next_state = S_RELEASE;
        end else begin
            case (cur_state)
                S_ATTACK: begin
                    n = base_a + fmul(cur_level, attack_l);
                    if (n >= ONE) begin
                        next_level = ONE;
                        next_state = S_DECAY;
                    end else begin
                        next_level = n;
                    end
                end
                S_DECAY: begin
                    n = base_d + fmul(cur_level, decay_l);
                    if (n <= sustain_f) begin
                        next_level = sustain_f;
                        next_state = S_SUSTAIN;
                    end else begin
                        next_level = n;
                    end
                end
                S_SUSTAIN: next_level = sustain_f;
                S_RELEASE: begin
                    n = base_r + fmul(cur_level, release_l);
                    // n <= 0, or it would already read as silence on the output
                    if (n[TOTAL_BITS-1] || n == '0 ||
                        n[FRACTIONAL_BITS-1 -: AMPLITUDE_BITS] == '0) begin
                        next_level = '0;
                        next_state = S_IDLE;
                    end else begin
                        next_level = n;
                    end
                end
                S_IDLE:  next_level = '0;
                default: begin
                    next_level = '0;
                    next_state = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                state_r[i] <= S_IDLE;
                level_r[i] <= '0;
            end
            gate_q    <= '0;
            idx       <= '0;
            attack_l  <= '0;
            decay_l   <= '0;
            release_l <= '0;
            sustain_l <= '0;
            out       <= '0;
            active    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                state_r[idx] <= next_state;
                level_r[idx] <= next_level;
                gate_q[idx]  <= cur_gate;
                out[idx*AMPLITUDE_BITS +: AMPLITUDE_BITS] <=
                    next_level[FRACTIONAL_BITS-1 -: AMPLITUDE_BITS];
                active[idx]  <= (next_state != S_IDLE);
                idx          <= idx + IDX_W'(1);
                if (idx == LAST_IDX) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end else if (tick && !done) begin
                busy      <= 1'b1;
                idx       <= '0;
                attack_l  <= attack_coef;
                decay_l   <= decay_coef;
                release_l <= release_coef;
                sustain_l <= sustain;
            end
        end
    end

endmodule

// File: tb/tb_adsr_poly.sv
// tb_adsr_poly: scoreboard bench for adsr_poly with 4 voices, 8-bit amplitude.
// Stimulus pushes the expected per-sweep out/active into a queue; a monitor
// pops and compares whenever done pulses.

module tb_adsr_poly;

    localparam int NV = 4;
    localparam int AB = 8;
    localparam int TW = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              tick;
    logic [NV-1:0]     gate;
    logic [TW-1:0]     attack_coef, decay_coef, release_coef;
    logic [AB-1:0]     sustain;
    logic [NV*AB-1:0]  out;
    logic [NV-1:0]     active;
    logic              busy, done;

    always #5 clk = ~clk;

    adsr_poly #(.NUM_VOICES(NV), .AMPLITUDE_BITS(AB)) dut (
        .clk(clk), .reset(reset), .tick(tick), .gate(gate),
        .attack_coef(attack_coef), .decay_coef(decay_coef),
        .release_coef(release_coef), .sustain(sustain),
        .out(out), .active(active), .busy(busy), .done(done)
    );

    int checks = 0;
    int errors = 0;
    int sweep_no = 0;

    typedef struct {
        logic [NV*AB-1:0] out;
        logic [NV-1:0]    active;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every done pulse is one completed sweep to score.
    always @(negedge clk) begin
        if (!reset && done) begin
            sweep_no++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done sweep=%0d actual=done required=no_done", sweep_no);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("sweep%0d_out", sweep_no), 64'(out), 64'(e.out));
                check($sformatf("sweep%0d_active", sweep_no), 64'(active), 64'(e.active));
            end
        end
    end

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL sweep_timeout actual=no_done required=done");
        end
    endtask

    task automatic sweep(input logic [NV*AB-1:0] eo, input logic [NV-1:0] ea);
        exp_q.push_back('{eo, ea});
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        wait_done();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit extra;
        reset = 1'b1; tick = 1'b0; gate = '0;
        attack_coef = '0; decay_coef = '0; release_coef = '0;
        sustain = 8'h80;
        #1;
        check("reset_out", 64'(out), 64'd0);
        check("reset_active", 64'(active), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Coefs 0, sustain 0x80: attack entry, full scale, sustain, hold.
        gate = 4'hF;
        sweep(32'h0000_0000, 4'hF);

        // Slot timing sweep with an ignored tick while busy.
        exp_q.push_back('{32'hFFFF_FFFF, 4'hF});
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        check("busy_after_accept", 64'(busy), 64'd1);
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            tick = (i == 1);
            check($sformatf("slot%0d_out", i), 64'(out[i*AB +: AB]), 64'hFF);
            if (i < NV - 1) begin
                check($sformatf("slot%0d_next_untouched", i), 64'(out[(i+1)*AB +: AB]), 64'h00);
                check($sformatf("slot%0d_busy", i), 64'(busy), 64'd1);
            end else begin
                check("last_slot_busy", 64'(busy), 64'd0);
                check("last_slot_done", 64'(done), 64'd1);
            end
        end
        @(posedge clk); #1;
        check("done_one_cycle", 64'(done), 64'd0);
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) extra = 1;
        end
        check("no_extra_done", 64'(extra), 64'd0);

        sweep(32'h8080_8080, 4'hF);
        sweep(32'h8080_8080, 4'hF);

        sustain = 8'h40;
        sweep(32'h4040_4040, 4'hF);

        // Voice 0 release from sustain.
        gate = 4'hE;
        sweep(32'h4040_4040, 4'hF);
        sweep(32'h4040_4000, 4'hE);

        // Attack with coef 0.5, release mid-attack, then re-gate.
        attack_coef  = 32'h0000_8000;
        release_coef = 32'h0000_8000;
        gate = 4'hF;
        sweep(32'h4040_4000, 4'hF);
        sweep(32'h4040_40A6, 4'hF);
        gate = 4'hE;
        sweep(32'h4040_40A6, 4'hF);
        sweep(32'h4040_4053, 4'hF);
        sweep(32'h4040_4029, 4'hF);
        gate = 4'hF;
`ifdef ADSR_POLY_HARD_RETRIG_EN
        sweep(32'h4040_4000, 4'hF);
        sweep(32'h4040_40A6, 4'hF);
        sweep(32'h4040_40F9, 4'hF);
`else
        sweep(32'h4040_4029, 4'hF);
        sweep(32'h4040_40BB, 4'hF);
        sweep(32'h4040_40FF, 4'hF);
`endif

        // Reset in the middle of a sweep.
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        exp_q.delete();
        check("midreset_out", 64'(out), 64'd0);
        check("midreset_active", 64'(active), 64'd0);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        attack_coef = '0; release_coef = '0;
        sustain = 8'h80;
        sweep(32'h0000_0000, 4'hF);
        sweep(32'hFFFF_FFFF, 4'hF);

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
